// File: rtl/bin_extract.sv
`timescale 1ns/1ps
// Captures all four channel FFT values at the peak bin; outvalid rises 5 clocks after the start edge is sampled.
// Holds the set until outvalid&&outready; a new frame arriving while pending sets sticky overrun.
// Optional DCREJECT_EN: a start edge with maxbin==0 is ignored (DC bin never captured).
module bin_extract (
    input  logic        clk,
    input  logic        reset,
    input  logic        detectdone,
    input  logic [9:0]  maxbin,
    input  logic [27:0] ramq0,
    input  logic [27:0] ramq1,
    input  logic [27:0] ramq2,
    input  logic [27:0] ramq3,
    output logic [9:0]  ramaddr,
    output logic [13:0] re0,
    output logic [13:0] re1,
    output logic [13:0] re2,
    output logic [13:0] re3,
    output logic [13:0] im0,
    output logic [13:0] im1,
    output logic [13:0] im2,
    output logic [13:0] im3,
    output logic [9:0]  binout,
    output logic        outvalid,
    input  logic        outready,
    output logic [7:0]  framecnt,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETADDR = 3'd1,
        WAIT1   = 3'd2,
        WAIT2   = 3'd3,
        CAPTURE = 3'd4,
        HOLD    = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic dd_s;
    logic dd_prev;
    logic start;
    logic go;
    logic accept;

    // Two registered samples of the level; the edge is judged on registered values only.
    assign start  = dd_s & ~dd_prev;
    assign accept = outvalid & outready;

`ifdef DCREJECT_EN
    assign go = start & (maxbin != 10'd0);
`else
    assign go = start;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = SETADDR;
            SETADDR: state_nxt = WAIT1;
            WAIT1:   state_nxt = WAIT2;
            WAIT2:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dd_s     <= 1'b0;
            dd_prev  <= 1'b0;
            ramaddr  <= 10'd0;
            binout   <= 10'd0;
            re0      <= 14'd0;
            re1      <= 14'd0;
            re2      <= 14'd0;
            re3      <= 14'd0;
            im0      <= 14'd0;
            im1      <= 14'd0;
            im2      <= 14'd0;
            im3      <= 14'd0;
            outvalid <= 1'b0;
            framecnt <= 8'd0;
            overrun  <= 1'b0;
        end else begin
            dd_s    <= detectdone;
            dd_prev <= dd_s;
            if (state == SETADDR) begin
                ramaddr <= maxbin;
                binout  <= maxbin;
            end
            // Two wait states cover the RAM read latency after ramaddr is registered.
            if (state == CAPTURE) begin
                re0      <= ramq0[27:14];
                im0      <= ramq0[13:0];
                re1      <= ramq1[27:14];
                im1      <= ramq1[13:0];
                re2      <= ramq2[27:14];
                im2      <= ramq2[13:0];
                re3      <= ramq3[27:14];
                im3      <= ramq3[13:0];
                outvalid <= 1'b1;
            end
            if (state == HOLD) begin
                if (accept) begin
                    outvalid <= 1'b0;
                    framecnt <= framecnt + 8'd1;
                end
                if (start) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_extract.sv
`timescale 1ns/1ps
// Scoreboard bench for bin_extract: directed frames push expected sets, a negedge monitor checks each accepted set.
module tb_bin_extract;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        detectdone = 1'b0;
    logic        outready = 1'b0;
    logic [9:0]  maxbin = 10'd0;
    logic [27:0] ramq0, ramq1, ramq2, ramq3;
    logic [9:0]  ramaddr;
    logic [13:0] re0, re1, re2, re3, im0, im1, im2, im3;
    logic [9:0]  binout;
    logic        outvalid;
    logic [7:0]  framecnt;
    logic        overrun;

    typedef struct packed {
        logic [9:0]       bin;
        logic [3:0][13:0] re;
        logic [3:0][13:0] im;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #10 clk = ~clk;

    bin_extract dut (
        .clk(clk), .reset(reset), .detectdone(detectdone), .maxbin(maxbin),
        .ramq0(ramq0), .ramq1(ramq1), .ramq2(ramq2), .ramq3(ramq3),
        .ramaddr(ramaddr),
        .re0(re0), .re1(re1), .re2(re2), .re3(re3),
        .im0(im0), .im1(im1), .im2(im2), .im3(im3),
        .binout(binout), .outvalid(outvalid), .outready(outready),
        .framecnt(framecnt), .overrun(overrun)
    );

    // RAM content: re = {ch, 2'b01, addr}, im = {~ch, 2'b10, ~addr}
    function automatic logic [27:0] ramword(input int n, input logic [9:0] a);
        logic [1:0]  nn;
        logic [13:0] r;
        logic [13:0] i;
        nn = n[1:0];
        r  = {nn, 2'b01, a};
        i  = {~nn, 2'b10, ~a};
        return {r, i};
    endfunction

    function automatic exp_t mk_exp(input logic [9:0] b);
        exp_t        e;
        logic [27:0] w;
        e.bin = b;
        for (int n = 0; n < 4; n++) begin
            w       = ramword(n, b);
            e.re[n] = w[27:14];
            e.im[n] = w[13:0];
        end
        return e;
    endfunction

    // Two-cycle read latency RAM model shared by all channels
    logic [9:0] addr_d1;
    always @(posedge clk) begin
        addr_d1 <= ramaddr;
        ramq0   <= ramword(0, addr_d1);
        ramq1   <= ramword(1, addr_d1);
        ramq2   <= ramword(2, addr_d1);
        ramq3   <= ramword(3, addr_d1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && outvalid && outready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: accepted bin 0x%0h with empty scoreboard", binout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_bin", 32'(binout), 32'(e.bin));
                chk("sb_re0", 32'(re0), 32'(e.re[0]));
                chk("sb_re1", 32'(re1), 32'(e.re[1]));
                chk("sb_re2", 32'(re2), 32'(e.re[2]));
                chk("sb_re3", 32'(re3), 32'(e.re[3]));
                chk("sb_im0", 32'(im0), 32'(e.im[0]));
                chk("sb_im1", 32'(im1), 32'(e.im[1]));
                chk("sb_im2", 32'(im2), 32'(e.im[2]));
                chk("sb_im3", 32'(im3), 32'(e.im[3]));
            end
        end
    end

    task automatic wait_valid(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = outvalid;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s: outvalid not seen within %0d cycles (got 0 required 1)", name, budget);
        end
    endtask

    task automatic accept_one();
        @(posedge clk); #1 outready = 1'b1;
        @(posedge clk); #1 outready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_hi;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outvalid", 32'(outvalid), 32'd0);
        chk("rst_framecnt", 32'(framecnt), 32'd0);
        chk("rst_overrun",  32'(overrun),  32'd0);
        chk("rst_ramaddr",  32'(ramaddr),  32'd0);
        chk("rst_binout",   32'(binout),   32'd0);
        chk("rst_re0",      32'(re0),      32'd0);
        @(posedge clk); #1 reset = 1'b1;

        // Basic capture at 0x155 with latency checks
        maxbin = 10'h155; detectdone = 1'b1;
        sb.push_back(mk_exp(10'h155));
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("basic_ramaddr", 32'(ramaddr), 32'h155);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("basic_early_valid", 32'(outvalid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("basic_valid_at5", 32'(outvalid), 32'd1);
        chk("basic_re0", 32'(re0), 32'h0555);
        chk("basic_im0", 32'(im0), 32'h3AAA);
        chk("basic_re3", 32'(re3), 32'h3555);
        chk("basic_binout", 32'(binout), 32'h155);

        // Backpressure
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bp_valid_held", 32'(outvalid), 32'd1);
        chk("bp_re0_stable", 32'(re0), 32'h0555);
        chk("bp_bin_stable", 32'(binout), 32'h155);
        chk("bp_framecnt_0", 32'(framecnt), 32'd0);
        accept_one();
        detectdone = 1'b0;
        @(negedge clk);
        chk("bp_valid_cleared", 32'(outvalid), 32'd0);
        chk("bp_framecnt_1", 32'(framecnt), 32'd1);

        // Overrun while holding
        @(posedge clk); #1 maxbin = 10'h2AA; detectdone = 1'b1;
        sb.push_back(mk_exp(10'h2AA));
        wait_valid("ovr_valid", 20);
        @(posedge clk); #1 detectdone = 1'b0;
        repeat (2) @(posedge clk);
        #1 detectdone = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_valid_held", 32'(outvalid), 32'd1);
        chk("ovr_bin", 32'(binout), 32'h2AA);
        chk("ovr_re1", 32'(re1), 32'h16AA);
        chk("ovr_im2", 32'(im2), 32'h1955);
        accept_one();
        detectdone = 1'b0;
        @(negedge clk);
        chk("ovr_framecnt_2", 32'(framecnt), 32'd2);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        pulse_reset();
        @(negedge clk);
        chk("ovr_cleared_by_rst", 32'(overrun), 32'd0);
        chk("rst2_framecnt", 32'(framecnt), 32'd0);

        // Reset while in WAIT2, then restart with detectdone still high
        @(posedge clk); #1 maxbin = 10'h0AB; detectdone = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 32'(outvalid), 32'd0);
        chk("midrst_ramaddr", 32'(ramaddr), 32'd0);
        chk("midrst_binout", 32'(binout), 32'd0);
        chk("midrst_re0", 32'(re0), 32'd0);
        chk("midrst_framecnt", 32'(framecnt), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        sb.push_back(mk_exp(10'h0AB));
        wait_valid("relhigh_valid", 20);
        chk("relhigh_bin", 32'(binout), 32'h0AB);
        accept_one();
        detectdone = 1'b0;
        @(negedge clk);
        chk("relhigh_framecnt", 32'(framecnt), 32'd1);

        // DC bin
        @(posedge clk); #1 maxbin = 10'd0; detectdone = 1'b1;
`ifdef DCREJECT_EN
        seen_hi = 0;
        repeat (12) begin
            @(negedge clk);
            if (outvalid) seen_hi++;
        end
        chk("dc_reject_valid", 32'(seen_hi), 32'd0);
        chk("dc_reject_framecnt", 32'(framecnt), 32'd1);
`else
        seen_hi = 0;
        sb.push_back(mk_exp(10'd0));
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        if (outvalid) seen_hi++;
        chk("dc_early_valid", 32'(seen_hi), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("dc_valid_at5", 32'(outvalid), 32'd1);
        chk("dc_binout", 32'(binout), 32'd0);
        accept_one();
        @(negedge clk);
        chk("dc_framecnt", 32'(framecnt), 32'd2);
`endif
        @(posedge clk); #1 detectdone = 1'b0;

        // 256 frames: framecnt wraps; last frame at 0x3FF
        pulse_reset();
        outready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [9:0] b;
            b = (i == 255) ? 10'h3FF : 10'(i * 4 + 1);
            @(posedge clk); #1 maxbin = b; detectdone = 1'b1;
            sb.push_back(mk_exp(b));
            wait_valid("wrap_valid", 20);
            @(posedge clk); #1 detectdone = 1'b0;
            if (i == 254) begin
                @(negedge clk);
                chk("wrap_framecnt_255", 32'(framecnt), 32'd255);
            end
        end
        @(negedge clk);
        chk("wrap_framecnt_0", 32'(framecnt), 32'd0);
        chk("wrap_valid_low", 32'(outvalid), 32'd0);
        chk("wrap_bin_3ff", 32'(binout), 32'h3FF);
        outready = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
